// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decode control and operands for EX, with stall hold,
// flush bubble insertion, slot validity and a saturating bubble counter for debug.
module id_ex_register #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               noop_i,
    input  logic               RegWrite_i,
    input  logic               MemtoReg_i,
    input  logic               MemRead_i,
    input  logic               MemWrite_i,
    input  logic               ALUSrc_i,
    input  logic [1:0]         ALUOp_i,
    input  logic [DATA_W-1:0]  RS1data_i,
    input  logic [DATA_W-1:0]  RS2data_i,
    input  logic [DATA_W-1:0]  imm_i,
    input  logic [9:0]         funct_i,
    input  logic [RADDR_W-1:0] RS1addr_i,
    input  logic [RADDR_W-1:0] RS2addr_i,
    input  logic [RADDR_W-1:0] RDaddr_i,
    output logic               RegWrite_o,
    output logic               MemtoReg_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               ALUSrc_o,
    output logic [1:0]         ALUOp_o,
    output logic [DATA_W-1:0]  RS1data_o,
    output logic [DATA_W-1:0]  RS2data_o,
    output logic [DATA_W-1:0]  imm_o,
    output logic [9:0]         funct_o,
    output logic [RADDR_W-1:0] RS1addr_o,
    output logic [RADDR_W-1:0] RS2addr_o,
    output logic [RADDR_W-1:0] RDaddr_o,
    output logic               valid_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic advance_c;
    logic count_c;

    // The slot advances only when running and not stalled; a flush or NoOp costs one bubble.
    always_comb begin
        advance_c = 1'b0;
        count_c   = 1'b0;
        advance_c = start_i & ~stall_i;
        count_c   = advance_c & (flush_i | noop_i) & (bubble_cnt_o != CNT_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            RegWrite_o   <= 1'b0;
            MemtoReg_o   <= 1'b0;
            MemRead_o    <= 1'b0;
            MemWrite_o   <= 1'b0;
            ALUSrc_o     <= 1'b0;
            ALUOp_o      <= 2'b00;
            RS1data_o    <= '0;
            RS2data_o    <= '0;
            imm_o        <= '0;
            funct_o      <= '0;
            RS1addr_o    <= '0;
            RS2addr_o    <= '0;
            RDaddr_o     <= '0;
            valid_o      <= 1'b0;
            bubble_cnt_o <= '0;
        end else begin
            if (advance_c) begin
                // Operand fields are don't-care in a bubble, so they load unconditionally.
                RS1data_o <= RS1data_i;
                RS2data_o <= RS2data_i;
                imm_o     <= imm_i;
                funct_o   <= funct_i;
                RS1addr_o <= RS1addr_i;
                RS2addr_o <= RS2addr_i;
                if (flush_i) begin
                    RegWrite_o <= 1'b0;
                    MemtoReg_o <= 1'b0;
                    MemRead_o  <= 1'b0;
                    MemWrite_o <= 1'b0;
                    ALUSrc_o   <= 1'b0;
                    ALUOp_o    <= 2'b00;
                    RDaddr_o   <= '0;
                    valid_o    <= 1'b0;
                end else begin
                    RegWrite_o <= RegWrite_i;
                    MemtoReg_o <= MemtoReg_i;
                    MemRead_o  <= MemRead_i;
                    MemWrite_o <= MemWrite_i;
                    ALUSrc_o   <= ALUSrc_i;
                    ALUOp_o    <= ALUOp_i;
                    RDaddr_o   <= RDaddr_i;
                    valid_o    <= ~noop_i;
                end
            end
            if (count_c) begin
                bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_ex_register.sv
// Directed bench for id_ex_register: spec-level model checked every cycle plus literal pins.
module tb_id_ex_register;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i, stall_i, flush_i, noop_i;
    logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i;
    logic [1:0]  ALUOp_i;
    logic [31:0] RS1data_i, RS2data_i, imm_i;
    logic [9:0]  funct_i;
    logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;

    logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, valid_o;
    logic [1:0]  ALUOp_o;
    logic [31:0] RS1data_o, RS2data_o, imm_o;
    logic [9:0]  funct_o;
    logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
    logic [15:0] bubble_cnt_o;

    logic        s_RegWrite_o, s_MemtoReg_o, s_MemRead_o, s_MemWrite_o, s_ALUSrc_o, s_valid_o;
    logic [1:0]  s_ALUOp_o;
    logic [31:0] s_RS1data_o, s_RS2data_o, s_imm_o;
    logic [9:0]  s_funct_o;
    logic [4:0]  s_RS1addr_o, s_RS2addr_o, s_RDaddr_o;
    logic [2:0]  s_bubble_cnt_o;

    int vectors = 0;
    int miscompares = 0;
    logic check_en = 1'b0;

    always #5 clk_i = ~clk_i;

    id_ex_register dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .flush_i(flush_i), .noop_i(noop_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i), .funct_i(funct_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
        .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .imm_o(imm_o), .funct_o(funct_o),
        .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
        .valid_o(valid_o), .bubble_cnt_o(bubble_cnt_o)
    );

    // Narrow-counter instance so saturation is reachable in a few cycles.
    id_ex_register #(.CNT_W(3)) dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .flush_i(flush_i), .noop_i(noop_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
        .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i), .funct_i(funct_i),
        .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
        .RegWrite_o(s_RegWrite_o), .MemtoReg_o(s_MemtoReg_o), .MemRead_o(s_MemRead_o),
        .MemWrite_o(s_MemWrite_o), .ALUSrc_o(s_ALUSrc_o), .ALUOp_o(s_ALUOp_o),
        .RS1data_o(s_RS1data_o), .RS2data_o(s_RS2data_o), .imm_o(s_imm_o), .funct_o(s_funct_o),
        .RS1addr_o(s_RS1addr_o), .RS2addr_o(s_RS2addr_o), .RDaddr_o(s_RDaddr_o),
        .valid_o(s_valid_o), .bubble_cnt_o(s_bubble_cnt_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: expected EX slot contents and bubble totals.
    logic        m_rw, m_mtr, m_mr, m_mw, m_as, m_valid, m_dc;
    logic [1:0]  m_op;
    logic [31:0] m_d1, m_d2, m_imm;
    logic [9:0]  m_fn;
    logic [4:0]  m_a1, m_a2, m_rd;
    int          m_cnt, m_cnt_s;

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            {m_rw, m_mtr, m_mr, m_mw, m_as, m_valid, m_dc} <= '0;
            m_op <= '0; m_d1 <= '0; m_d2 <= '0; m_imm <= '0; m_fn <= '0;
            m_a1 <= '0; m_a2 <= '0; m_rd <= '0;
            m_cnt <= 0; m_cnt_s <= 0;
        end else if (start_i && !stall_i) begin
            if (flush_i || noop_i) begin
                m_cnt   <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
                m_cnt_s <= (m_cnt_s < 7) ? m_cnt_s + 1 : 7;
            end
            if (flush_i) begin
                {m_rw, m_mtr, m_mr, m_mw, m_as} <= '0;
                m_op <= 2'b00; m_rd <= '0; m_valid <= 1'b0; m_dc <= 1'b1;
            end else begin
                {m_rw, m_mtr, m_mr, m_mw, m_as} <= {RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i};
                m_op <= ALUOp_i; m_rd <= RDaddr_i; m_valid <= !noop_i; m_dc <= 1'b0;
                m_d1 <= RS1data_i; m_d2 <= RS2data_i; m_imm <= imm_i; m_fn <= funct_i;
                m_a1 <= RS1addr_i; m_a2 <= RS2addr_i;
            end
        end
    end

    always @(negedge clk_i) begin
        if (check_en && rst_i) begin
            chk("valid", 64'(valid_o), 64'(m_valid));
            chk("ctrl", 64'({RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o}),
                64'({m_rw, m_mtr, m_mr, m_mw, m_as}));
            chk("ALUOp", 64'(ALUOp_o), 64'(m_op));
            chk("RDaddr", 64'(RDaddr_o), 64'(m_rd));
            chk("bubble_cnt", 64'(bubble_cnt_o), 64'(m_cnt));
            chk("s_bubble_cnt", 64'(s_bubble_cnt_o), 64'(m_cnt_s));
            chk("s_valid", 64'(s_valid_o), 64'(m_valid));
            if (!m_dc) begin
                chk("RS1data", 64'(RS1data_o), 64'(m_d1));
                chk("RS2data", 64'(RS2data_o), 64'(m_d2));
                chk("imm", 64'(imm_o), 64'(m_imm));
                chk("funct", 64'(funct_o), 64'(m_fn));
                chk("RSaddr", 64'({RS1addr_o, RS2addr_o}), 64'({m_a1, m_a2}));
            end
            if (!valid_o) chk("bubble_safe", 64'({RegWrite_o, MemWrite_o, MemRead_o}), 64'd0);
        end
    end

    task automatic drive(input logic rw, input logic mtr, input logic mr, input logic mw,
                         input logic as, input logic [1:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] im, input logic [9:0] fn,
                         input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd);
        RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw; ALUSrc_i = as;
        ALUOp_i = op; RS1data_i = d1; RS2data_i = d2; imm_i = im; funct_i = fn;
        RS1addr_i = a1; RS2addr_i = a2; RDaddr_i = rd;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0;
        {start_i, stall_i, flush_i, noop_i} = 4'b0000;
        drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_valid", 64'(valid_o), 64'd0);
        chk("reset_cnt", 64'(bubble_cnt_o), 64'd0);
        chk("reset_RS1data", 64'(RS1data_o), 64'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        check_en = 1'b1;

        // add x3,x1,x2
        start_i = 1'b1;
        drive(1, 0, 0, 0, 0, 2'b10, 32'd5, 32'd7, 32'd0, 10'h000, 5'd1, 5'd2, 5'd3);
        step();
        chk("add_RegWrite", 64'(RegWrite_o), 64'd1);
        chk("add_ALUOp", 64'(ALUOp_o), 64'd2);
        chk("add_RS1data", 64'(RS1data_o), 64'd5);
        chk("add_RS2data", 64'(RS2data_o), 64'd7);
        chk("add_RDaddr", 64'(RDaddr_o), 64'd3);
        chk("add_valid", 64'(valid_o), 64'd1);
        chk("add_cnt", 64'(bubble_cnt_o), 64'd0);

        // stall for 3 cycles with churning inputs and flush asserted
        stall_i = 1'b1;
        flush_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 1, 1, 2'(i), 32'(100 + i), 32'(200 + i), 32'hFFFF_FFF0, 10'(i), 5'(i), 5'(i + 4), 5'(i + 8));
            step();
            chk("stall_RS1data", 64'(RS1data_o), 64'd5);
            chk("stall_RDaddr", 64'(RDaddr_o), 64'd3);
            chk("stall_cnt", 64'(bubble_cnt_o), 64'd0);
        end
        stall_i = 1'b0;
        step();
        chk("rel_flush_valid", 64'(valid_o), 64'd0);
        chk("rel_flush_RegWrite", 64'(RegWrite_o), 64'd0);
        chk("rel_flush_RDaddr", 64'(RDaddr_o), 64'd0);
        chk("rel_flush_cnt", 64'(bubble_cnt_o), 64'd1);

        // hazard NoOp, then lw
        flush_i = 1'b0;
        noop_i = 1'b1;
        drive(0, 0, 0, 0, 0, 2'b00, 32'h11, 32'h22, 32'h0, 10'h0, 5'd6, 5'd7, 5'd0);
        step();
        chk("noop_valid", 64'(valid_o), 64'd0);
        chk("noop_RegWrite", 64'(RegWrite_o), 64'd0);
        chk("noop_cnt", 64'(bubble_cnt_o), 64'd2);
        noop_i = 1'b0;
        drive(1, 1, 1, 0, 1, 2'b00, 32'h1000, 32'h0, 32'd16, 10'h002, 5'd2, 5'd0, 5'd4);
        step();
        chk("lw_valid", 64'(valid_o), 64'd1);
        chk("lw_MemRead", 64'(MemRead_o), 64'd1);
        chk("lw_imm", 64'(imm_o), 64'd16);
        chk("lw_cnt", 64'(bubble_cnt_o), 64'd2);

        // flushed sw
        flush_i = 1'b1;
        drive(0, 0, 0, 1, 1, 2'b00, 32'h2000, 32'hCAFE, 32'd8, 10'h002, 5'd5, 5'd9, 5'd9);
        step();
        chk("sw_flush_MemWrite", 64'(MemWrite_o), 64'd0);
        chk("sw_flush_RDaddr", 64'(RDaddr_o), 64'd0);
        chk("sw_flush_valid", 64'(valid_o), 64'd0);
        chk("sw_flush_cnt", 64'(bubble_cnt_o), 64'd3);

        // flush and noop together count once
        noop_i = 1'b1;
        step();
        chk("flush_noop_cnt", 64'(bubble_cnt_o), 64'd4);

        // start low holds everything, even with flush asserted
        noop_i = 1'b0;
        start_i = 1'b0;
        drive(1, 0, 0, 0, 0, 2'b10, 32'd5, 32'd7, 32'd0, 10'h000, 5'd1, 5'd2, 5'd3);
        step();
        chk("hold_cnt", 64'(bubble_cnt_o), 64'd4);
        chk("hold_valid", 64'(valid_o), 64'd0);

        start_i = 1'b1;
        flush_i = 1'b0;
        drive(1, 0, 0, 0, 0, 2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_F800, 10'h3FF, 5'd30, 5'd29, 5'd31);
        step();
        chk("beq_valid", 64'(valid_o), 64'd1);
        chk("beq_RDaddr", 64'(RDaddr_o), 64'd31);
        chk("beq_RS1data", 64'(RS1data_o), 64'hDEAD_BEEF);
        chk("beq_funct", 64'(funct_o), 64'h3FF);

        // async reset mid-cycle with nonzero outputs
        #2;
        rst_i = 1'b0;
        #1;
        chk("midrst_valid", 64'(valid_o), 64'd0);
        chk("midrst_RegWrite", 64'(RegWrite_o), 64'd0);
        chk("midrst_RS1data", 64'(RS1data_o), 64'd0);
        chk("midrst_RDaddr", 64'(RDaddr_o), 64'd0);
        chk("midrst_ALUOp", 64'(ALUOp_o), 64'd0);
        chk("midrst_cnt", 64'(bubble_cnt_o), 64'd0);
        #2;
        rst_i = 1'b1;
        step();
        chk("post_rst_valid", 64'(valid_o), 64'd1);

        // mixed directed vectors checked by the model
        for (int i = 0; i < 6; i++) begin
            stall_i = (i == 2);
            noop_i  = (i == 4);
            drive(1'(i), 1'(i >> 1), 1'(i >> 2), 1'(i == 5), 1'(i == 3), 2'(i), 32'(i * 32'h0101_0101),
                  32'(~i), 32'(i << 4), 10'(i * 37), 5'(i + 10), 5'(i + 20), 5'(i + 1));
            if (i == 4) drive(0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 32'h0, 10'h0, 5'd0, 5'd0, 5'd0);
            step();
        end
        stall_i = 1'b0;
        noop_i = 1'b0;
        chk("mix_cnt", 64'(bubble_cnt_o), 64'd1);

        // drive the narrow counter into saturation
        flush_i = 1'b1;
        repeat (5) step();
        chk("sat_s_cnt6", 64'(s_bubble_cnt_o), 64'd6);
        repeat (2) step();
        chk("sat_s_cnt7", 64'(s_bubble_cnt_o), 64'd7);
        chk("sat_cnt8", 64'(bubble_cnt_o), 64'd8);
        step();
        chk("sat_s_hold", 64'(s_bubble_cnt_o), 64'd7);
        chk("sat_cnt9", 64'(bubble_cnt_o), 64'd9);

        flush_i = 1'b0;
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
